// File: rtl/aes_inv_key_sched128_pkg.sv
// Shared types and constants for the reverse-order AES-128 key schedule.
package aes_pkg;

  localparam int NR   = 10;   // rounds in AES-128
  localparam int Nk   = 4;    // 32-bit words per cipher key
  localparam int RK_W = 128;  // round-key width

  // Byte 0 sits in bits 0:7 (FIPS-197 order).
  typedef logic [0:31]     word_t;
  typedef logic [0:RK_W-1] rkey_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [7:0] RCON_TAB [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant as a word; any round index outside 1..10 yields zero.
  function automatic word_t rcon(input logic [3:0] r);
    word_t w;
    w = '0;
    if (r >= 4'd1 && r <= 4'd10) w[0:7] = RCON_TAB[r];
    return w;
  endfunction

endpackage

// File: rtl/aes_inv_key_sched128_sbox.sv
// Combinational 8-bit forward AES S-box (table lookup).
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry n of the table occupies bits [8n : 8n+7].
  localparam logic [0:2047] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Pure lookup: byte index scaled to a bit offset.
  always_comb begin
    out_o = SBOX_TAB[{in_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_inv_key_sched128.sv
// Iterative AES-128 key schedule emitting round keys 10 down to 0.
// A forward pass expands the cipher key to round 10; the reverse pass
// streams each key over valid/ready and regenerates its predecessor.
// Optional macro AES_INV_KS_DIRECT_LAST_EN adds load_last, which loads
// key_in as the round-10 key and skips the forward pass.
//
// Handshake: rk_valid/rk_out/rk_round/rk_last are decoded from registers
// only; a key transfers on a rising edge where rk_valid && rk_ready, and
// while rk_ready is low everything offered holds stable.
module aes_inv_key_sched128
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef AES_INV_KS_DIRECT_LAST_EN
  input  logic        load_last,
`endif
  input  rkey_t       key_in,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output rkey_t       rk_out,
  output logic [3:0]  rk_round,
  output logic        rk_last,
  output state_e      dbg_state_o
);

  localparam logic [3:0] NR_C = 4'(NR);

  state_e     state_q;
  logic [3:0] cnt_q;
  rkey_t      w_q;

  word_t      c0, c1, c2, c3;
  word_t      p3, sb_in, rot_w, sub_w, rcon_w;
  logic [3:0] rcon_idx;
  word_t      n0, n1, n2, n3;
  word_t      q0, q1, q2;
  rkey_t      w_fwd_d, w_rev_d;

  assign {c0, c1, c2, c3} = w_q;

  // One S-box bank serves both directions: forward needs w3, reverse needs
  // the regenerated previous w3 (c3 ^ c2). Rcon index follows the same split.
  always_comb begin
    p3       = c3 ^ c2;
    sb_in    = (state_q == OUT) ? p3 : c3;
    rot_w    = {sb_in[8:31], sb_in[0:7]};
    rcon_idx = (state_q == OUT) ? cnt_q : cnt_q + 4'd1;
    rcon_w   = rcon(rcon_idx);
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_w[8*i +: 8]),
      .out_o (sub_w[8*i +: 8])
    );
  end

  // Forward step next() and reverse step prev() of the key expansion.
  always_comb begin
    n0      = c0 ^ sub_w ^ rcon_w;
    n1      = c1 ^ n0;
    n2      = c2 ^ n1;
    n3      = c3 ^ n2;
    w_fwd_d = {n0, n1, n2, n3};
    q2      = c2 ^ c1;
    q1      = c1 ^ c0;
    q0      = c0 ^ sub_w ^ rcon_w;
    w_rev_d = {q0, q1, q2, p3};
  end

  // Control FSM with working register and round counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            w_q <= key_in;
`ifdef AES_INV_KS_DIRECT_LAST_EN
            if (load_last) begin
              cnt_q   <= NR_C;
              state_q <= OUT;
            end else begin
              cnt_q   <= '0;
              state_q <= FWD;
            end
`else
            cnt_q   <= '0;
            state_q <= FWD;
`endif
          end
        end
        FWD: begin
          w_q   <= w_fwd_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == NR_C - 4'd1) state_q <= OUT;
        end
        OUT: begin
          if (rk_ready) begin
            if (cnt_q == 4'd0) begin
              state_q <= IDLE;
            end else begin
              w_q   <= w_rev_d;
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign rk_valid    = (state_q == OUT);
  assign rk_out      = w_q;
  assign rk_round    = cnt_q;
  assign rk_last     = (state_q == OUT) && (cnt_q == 4'd0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_inv_key_sched128.sv
// Directed bench for the reverse-order AES-128 key schedule.
module tb_aes_inv_key_sched128;
  import aes_pkg::*;

  localparam int EXP_W = 134;

  typedef struct packed {
    logic         chk;
    logic [3:0]   round;
    logic         last;
    logic [127:0] key;
  } exp_t;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready;
  logic         busy, rk_valid, rk_last;
  logic [0:127] key_in, rk_out;
  logic [3:0]   rk_round;
  state_e       dbg_state;
`ifdef AES_INV_KS_DIRECT_LAST_EN
  logic         load_last;
`endif

  logic [EXP_W-1:0] exp_q[$];
  vec_t             fips[11];
  int               n_tests = 0;
  int               n_fail  = 0;

  aes_inv_key_sched128 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef AES_INV_KS_DIRECT_LAST_EN
    .load_last   (load_last),
`endif
    .key_in      (key_in),
    .busy        (busy),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_out      (rk_out),
    .rk_round    (rk_round),
    .rk_last     (rk_last),
    .dbg_state_o (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic load_fips_exp();
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 11; i++) begin
      e.chk   = 1'b1;
      e.round = fips[i].round;
      e.last  = (fips[i].round == 4'd0);
      e.key   = fips[i].key;
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue_start(input logic [127:0] k, input logic ll);
    start  = 1'b1;
    key_in = k;
`ifdef AES_INV_KS_DIRECT_LAST_EN
    load_last = ll;
`else
    if (ll) fail_now("load_last_unsupported");
`endif
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
`ifdef AES_INV_KS_DIRECT_LAST_EN
    load_last = 1'b0;
`endif
  endtask

  // Counts edges (sampling edge = 1) until rk_valid; optional start pulses.
  task automatic wait_valid(input int exp_lat, input bit pulse_start);
    int lat;
    lat = 1;
    while (!rk_valid && lat < 40) begin
      check("busy_fwd", 128'(busy), 128'(1'b1));
      if (pulse_start && (lat % 3 == 0)) begin
        start  = 1'b1;
        key_in = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!rk_valid) fail_now("wait_valid");
    check("latency", 128'(lat), 128'(exp_lat));
  endtask

  // Drains the stream against exp_q; checks stability while stalled.
  task automatic stream(input bit rnd, input bit pulse_start, input int exp_n);
    int           cyc, nkeys;
    bit           done, held;
    logic [127:0] hk;
    logic [3:0]   hr;
    exp_t         e;
    cyc = 0; nkeys = 0; done = 0; held = 0; hk = '0; hr = '0;
    while (!done && cyc < 300) begin
      check("valid_hold", 128'(rk_valid), 128'(1'b1));
      if (held) begin
        check("stall_key", rk_out, hk);
        check("stall_round", 128'(rk_round), 128'(hr));
      end
      rk_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pulse_start) begin
        start  = rk_last ? 1'b1 : 1'($urandom_range(0, 1));
        key_in = '0;
      end
      if (rk_ready && rk_valid) begin
        nkeys++;
        if (exp_q.size() == 0) begin
          fail_now("exp_q_empty");
          done = 1;
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check("rk_out", rk_out, e.key);
          check("rk_round", 128'(rk_round), 128'(e.round));
          check("rk_last", 128'(rk_last), 128'(e.last));
          if (e.last) done = 1;
        end
      end
      held = !rk_ready;
      hk   = rk_out;
      hr   = rk_round;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    if (!done) fail_now("stream");
    check("n_keys", 128'(nkeys), 128'(exp_n));
    check("busy_end", 128'(busy), 128'(1'b0));
    check("valid_end", 128'(rk_valid), 128'(1'b0));
    repeat (3) @(negedge clk);
    check("idle_after", 128'(busy), 128'(1'b0));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(1'b0));
    check({tag, "_valid"}, 128'(rk_valid), 128'(1'b0));
    check({tag, "_rk_out"}, rk_out, 128'h0);
    check({tag, "_round"}, 128'(rk_round), 128'h0);
    check({tag, "_last"}, 128'(rk_last), 128'(1'b0));
  endtask

  initial begin
    exp_t e;
    fips[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    fips[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

    // Reset
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
`ifdef AES_INV_KS_DIRECT_LAST_EN
    load_last = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    check("reset_state", 128'(dbg_state), 128'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS key, ready held high
    load_fips_exp();
    issue_start(fips[10].key, 1'b0);
    wait_valid(11, 1'b0);
    stream(1'b0, 1'b0, 11);

    // Random backpressure
    load_fips_exp();
    issue_start(fips[10].key, 1'b0);
    wait_valid(11, 1'b0);
    stream(1'b1, 1'b0, 11);

    // Start pulses during FWD and OUT, including the final handshake
    load_fips_exp();
    issue_start(fips[10].key, 1'b0);
    wait_valid(11, 1'b1);
    stream(1'b1, 1'b1, 11);

    // Reset at FWD cycle 5
    issue_start(fips[10].key, 1'b0);
    repeat (4) @(negedge clk);
    check("fwd_busy_pre_rst", 128'(busy), 128'(1'b1));
    rst_n = 1'b0;
    @(negedge clk);
    check_cleared("rst_fwd");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-OUT after three keys
    issue_start(fips[10].key, 1'b0);
    wait_valid(11, 1'b0);
    rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("out_round_pre_rst", 128'(rk_round), 128'(4'd7));
    rk_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_cleared("rst_out");
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh schedule after the aborts
    load_fips_exp();
    issue_start(fips[10].key, 1'b0);
    wait_valid(11, 1'b0);
    stream(1'b1, 1'b0, 11);

    // All-zero key: only rounds 10 and 0 are known
    exp_q.delete();
    for (int r = 10; r >= 0; r--) begin
      e.chk   = (r == 10) || (r == 0);
      e.round = 4'(r);
      e.last  = (r == 0);
      e.key   = (r == 10) ? 128'hb4ef5bcb3e92e21123e951cf6f8f188e : 128'h0;
      exp_q.push_back(e);
    end
    issue_start(128'h0, 1'b0);
    wait_valid(11, 1'b0);
    stream(1'b0, 1'b0, 11);

`ifdef AES_INV_KS_DIRECT_LAST_EN
    // Direct load of the round-10 key
    load_fips_exp();
    issue_start(fips[0].key, 1'b1);
    wait_valid(1, 1'b0);
    stream(1'b1, 1'b0, 11);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
